// File: rtl/flexka_recursion_sequencer.sv
// Depth-first Karatsuba recursion walker: issues leaf multiply jobs,
// one combine job per internal node, and drives the external size stack.
module flexka_recursion_sequencer #(
  parameter int SSIZE     = 32,
  parameter int LEAF_SIZE = 64,
  parameter int MAX_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SSIZE-1:0] size_A,
  input  logic [SSIZE-1:0] size_B,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             leaf_valid,
  input  logic             leaf_ready,
  output logic [SSIZE-1:0] leaf_size_A,
  output logic [SSIZE-1:0] leaf_size_B,
  output logic [SSIZE-1:0] leaf_depth,
  output logic [1:0]       leaf_child,
  output logic             comb_valid,
  input  logic             comb_ready,
  output logic [SSIZE-1:0] comb_size_A,
  output logic [SSIZE-1:0] comb_size_B,
  output logic [SSIZE-1:0] comb_depth,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [SSIZE-1:0] stk_in_A2,
  output logic [SSIZE-1:0] stk_in_B2,
  input  logic [SSIZE-1:0] stk_top_A2,
  input  logic [SSIZE-1:0] stk_top_B2,
  output logic [SSIZE-1:0] depth
);

  localparam int DW = $clog2(MAX_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_LEAF, S_DESCEND,
    S_RETURN, S_RESTORE, S_COMBINE, S_DONE
  } state_t;

  state_t           state;
  logic [SSIZE-1:0] cur_a, cur_b;
  logic [1:0]       cur_child;
  logic [1:0]       child_idx [MAX_DEPTH+1];
  logic [DW-1:0]    didx;
  logic [1:0]       k;
  logic [2*SSIZE-1:0] c0, cn;
  logic             is_zero, is_leaf, at_max;

  // (max+1)>>1 written as (max>>1)+lsb so it cannot overflow SSIZE bits
  function automatic logic [2*SSIZE-1:0] child_of(
    input logic [SSIZE-1:0] a,
    input logic [SSIZE-1:0] b,
    input logic [1:0]       idx
  );
    logic [SSIZE-1:0] mx, hs, ca, cb;
    mx = (a > b) ? a : b;
    hs = {1'b0, mx[SSIZE-1:1]} + {{(SSIZE-1){1'b0}}, mx[0]};
    case (idx)
      2'd0: begin
        ca = (a < hs) ? a : hs;
        cb = (b < hs) ? b : hs;
      end
      2'd1: begin
        ca = (a > hs) ? a - hs : '0;
        cb = (b > hs) ? b - hs : '0;
      end
      default: begin
        ca = hs + SSIZE'(1);
        cb = hs + SSIZE'(1);
      end
    endcase
    return {ca, cb};
  endfunction

  assign didx    = depth[DW-1:0];
  assign k       = child_idx[didx];
  assign c0      = child_of(cur_a, cur_b, 2'd0);
  assign cn      = child_of(stk_top_A2, stk_top_B2, k + 2'd1);
  assign is_zero = (cur_a == '0) || (cur_b == '0);
  assign is_leaf = (cur_a <= SSIZE'(LEAF_SIZE)) &&
                   (cur_b <= SSIZE'(LEAF_SIZE));
  assign at_max  = (depth == SSIZE'(MAX_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_a       <= '0;
      cur_b       <= '0;
      cur_child   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      leaf_valid  <= 1'b0;
      leaf_size_A <= '0;
      leaf_size_B <= '0;
      leaf_depth  <= '0;
      leaf_child  <= '0;
      comb_valid  <= 1'b0;
      comb_size_A <= '0;
      comb_size_B <= '0;
      comb_depth  <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_in_A2   <= '0;
      stk_in_B2   <= '0;
      depth       <= '0;
      for (int i = 0; i <= MAX_DEPTH; i++) child_idx[i] <= '0;
    end else begin
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          cur_a     <= size_A;
          cur_b     <= size_B;
          cur_child <= '0;
          depth     <= '0;
          error     <= 1'b0;
          busy      <= 1'b1;
          state     <= S_EVAL;
        end
        S_EVAL: begin
          if (is_zero) begin
            state <= S_RETURN;
          end else if (is_leaf) begin
            leaf_valid  <= 1'b1;
            leaf_size_A <= cur_a;
            leaf_size_B <= cur_b;
            leaf_depth  <= depth;
            leaf_child  <= cur_child;
            state       <= S_LEAF;
          end else begin
            state <= S_DESCEND;
          end
        end
        S_LEAF: if (leaf_ready) begin
          leaf_valid <= 1'b0;
          state      <= S_RETURN;
        end
        S_DESCEND: begin
          if (at_max) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            stk_push        <= 1'b1;
            stk_in_A2       <= cur_a;
            stk_in_B2       <= cur_b;
            child_idx[didx] <= 2'd0;
            {cur_a, cur_b}  <= c0;
            cur_child       <= 2'd0;
            depth           <= depth + SSIZE'(1);
            state           <= S_EVAL;
          end
        end
        S_RETURN: begin
          if (depth == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            stk_pop <= 1'b1;
            depth   <= depth - SSIZE'(1);
            state   <= S_RESTORE;
          end
        end
        // first cycle is the pop itself; the top entry is usable one cycle later
        S_RESTORE: if (!stk_pop) begin
          if (k != 2'd2) begin
            stk_push        <= 1'b1;
            stk_in_A2       <= stk_top_A2;
            stk_in_B2       <= stk_top_B2;
            child_idx[didx] <= k + 2'd1;
            {cur_a, cur_b}  <= cn;
            cur_child       <= k + 2'd1;
            depth           <= depth + SSIZE'(1);
            state           <= S_EVAL;
          end else begin
            comb_valid  <= 1'b1;
            comb_size_A <= stk_top_A2;
            comb_size_B <= stk_top_B2;
            comb_depth  <= depth;
            state       <= S_COMBINE;
          end
        end
        S_COMBINE: if (comb_ready) begin
          comb_valid <= 1'b0;
          cur_a      <= comb_size_A;
          cur_b      <= comb_size_B;
          state      <= S_RETURN;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flexka_recursion_sequencer.sv
// Randomized scoreboard bench for flexka_recursion_sequencer with a
// work-list reference model of the recursion and a behavioural size stack.
module tb_flexka_recursion_sequencer;

  localparam int SS   = 32;
  localparam int LEAF = 64;
  localparam int MAXD = 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [SS-1:0] size_A, size_B;
  logic          busy, done, error;
  logic          leaf_valid, leaf_ready;
  logic [SS-1:0] leaf_size_A, leaf_size_B, leaf_depth;
  logic [1:0]    leaf_child;
  logic          comb_valid, comb_ready;
  logic [SS-1:0] comb_size_A, comb_size_B, comb_depth;
  logic          stk_push, stk_pop;
  logic [SS-1:0] stk_in_A2, stk_in_B2;
  logic [SS-1:0] stk_top_A2, stk_top_B2;
  logic [SS-1:0] depth;

  flexka_recursion_sequencer #(
    .SSIZE(SS), .LEAF_SIZE(LEAF), .MAX_DEPTH(MAXD)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .size_A(size_A), .size_B(size_B),
    .busy(busy), .done(done), .error(error),
    .leaf_valid(leaf_valid), .leaf_ready(leaf_ready),
    .leaf_size_A(leaf_size_A), .leaf_size_B(leaf_size_B),
    .leaf_depth(leaf_depth), .leaf_child(leaf_child),
    .comb_valid(comb_valid), .comb_ready(comb_ready),
    .comb_size_A(comb_size_A), .comb_size_B(comb_size_B),
    .comb_depth(comb_depth),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_in_A2(stk_in_A2), .stk_in_B2(stk_in_B2),
    .stk_top_A2(stk_top_A2), .stk_top_B2(stk_top_B2),
    .depth(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     kind;
    longint a;
    longint b;
    int     d;
    int     c;
  } ev_t;

  typedef struct {
    bit     comb;
    longint a;
    longint b;
    int     d;
    int     c;
  } wk_t;

  ev_t expq[$];
  ev_t mon_e;
  logic [2*SS-1:0] stk[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  push_cnt = 0;
  int  pop_cnt = 0;
  bit  hold_leaf = 0;
  bit  hold_comb = 0;

  wire any_out = |{busy, done, error, leaf_valid, leaf_size_A,
                   leaf_size_B, leaf_depth, leaf_child, comb_valid,
                   comb_size_A, comb_size_B, comb_depth, stk_push,
                   stk_pop, stk_in_A2, stk_in_B2, depth};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected event order: depth-first, child 0,1,2 then the parent's combine
  task automatic model_job(input longint a, input longint b,
                           output bit err, output int nint);
    wk_t    wl[$];
    wk_t    w;
    longint h, mx;
    err  = 0;
    nint = 0;
    wl.push_back('{0, a, b, 0, 0});
    while (wl.size() > 0 && !err) begin
      w = wl.pop_back();
      if (w.comb) begin
        expq.push_back('{1, w.a, w.b, w.d, 0});
      end else if (w.a == 0 || w.b == 0) begin
      end else if (w.a <= LEAF && w.b <= LEAF) begin
        expq.push_back('{0, w.a, w.b, w.d, w.c});
      end else if (w.d == MAXD) begin
        err = 1;
      end else begin
        nint++;
        mx = (w.a > w.b) ? w.a : w.b;
        h  = (mx + 1) / 2;
        wl.push_back('{1, w.a, w.b, w.d, 0});
        wl.push_back('{0, h + 1, h + 1, w.d + 1, 2});
        wl.push_back('{0, (w.a > h) ? w.a - h : 0,
                       (w.b > h) ? w.b - h : 0, w.d + 1, 1});
        wl.push_back('{0, (w.a < h) ? w.a : h,
                       (w.b < h) ? w.b : h, w.d + 1, 0});
      end
    end
    expq.push_back('{2, longint'(err), 0, 0, 0});
  endtask

  // size stack node: entry presented the cycle after the pop
  always @(posedge clk) begin
    if (rst) begin
      stk.delete();
      stk_top_A2 <= '0;
      stk_top_B2 <= '0;
    end else begin
      if (stk_push) begin
        stk.push_back({stk_in_A2, stk_in_B2});
        push_cnt <= push_cnt + 1;
      end
      if (stk_pop) begin
        pop_cnt <= pop_cnt + 1;
        if (stk.size() > 0) {stk_top_A2, stk_top_B2} <= stk.pop_back();
      end
    end
  end

  initial begin
    leaf_ready = 1'b0;
    comb_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      leaf_ready = !hold_leaf && ($urandom_range(0, 3) != 0);
      comb_ready = !hold_comb && ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("push_pop_excl", {63'd0, stk_push & stk_pop}, 0);
      chk("valid_excl", {63'd0, leaf_valid & comb_valid}, 0);
      if ((leaf_valid && leaf_ready) || (comb_valid && comb_ready) || done) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: leaf=%0b comb=%0b done=%0b, none expected",
                   leaf_valid, comb_valid, done);
        end else begin
          mon_e = expq.pop_front();
          if (leaf_valid && leaf_ready) begin
            chk("leaf_kind", 0, mon_e.kind);
            chk("leaf_size_A", leaf_size_A, mon_e.a);
            chk("leaf_size_B", leaf_size_B, mon_e.b);
            chk("leaf_depth", leaf_depth, mon_e.d);
            chk("leaf_child", leaf_child, mon_e.c);
          end else if (comb_valid && comb_ready) begin
            chk("comb_kind", 1, mon_e.kind);
            chk("comb_size_A", comb_size_A, mon_e.a);
            chk("comb_size_B", comb_size_B, mon_e.b);
            chk("comb_depth", comb_depth, mon_e.d);
          end else begin
            chk("done_kind", 2, mon_e.kind);
            chk("done_error", error, mon_e.a);
            chk("done_busy_low", busy, 0);
          end
        end
      end
    end
  end

  task automatic start_job(input logic [SS-1:0] a, input logic [SS-1:0] b);
    @(posedge clk);
    #1;
    size_A = a;
    size_B = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared_on_start", error, 0);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (n < 20000) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk({nm, "_done_seen"}, done, 1);
    @(negedge clk);
    chk({nm, "_busy_after_done"}, busy, 0);
    chk({nm, "_scoreboard_empty"}, expq.size(), 0);
  endtask

  task automatic run_job(input logic [SS-1:0] a, input logic [SS-1:0] b,
                         input string nm);
    bit err;
    int ni, p0, q0;
    model_job(a, b, err, ni);
    p0 = push_cnt;
    q0 = pop_cnt;
    start_job(a, b);
    wait_done(nm);
    if (!err) begin
      chk({nm, "_pushes"}, push_cnt - p0, 3 * ni);
      chk({nm, "_pops"}, pop_cnt - q0, 3 * ni);
    end
  endtask

  logic [4*SS+1:0] snap;
  logic [SS-1:0]   snap_d;

  initial begin
    bit err;
    int ni, n;
    rst    = 1'b1;
    start  = 1'b0;
    size_A = '0;
    size_B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", any_out, 0);
    chk("reset_depth", depth, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_job(64, 64, "single_leaf");
    run_job(128, 128, "two_level");
    run_job(100, 40, "skewed");

    hold_leaf = 1;
    model_job(64, 64, err, ni);
    start_job(64, 64);
    n = 0;
    while (!leaf_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_leaf_seen", leaf_valid, 1);
    snap   = {leaf_size_A, leaf_size_B, leaf_depth, leaf_child};
    snap_d = depth;
    repeat (10) begin
      @(negedge clk);
      chk("stall_leaf_valid", leaf_valid, 1);
      chk("stall_leaf_stable",
          {leaf_size_A, leaf_size_B, leaf_depth, leaf_child} == snap, 1);
      chk("stall_no_stack", {62'd0, stk_push, stk_pop}, 0);
      chk("stall_depth", depth, snap_d);
    end
    hold_leaf = 0;
    wait_done("stall");

    run_job(32'h0010_0000, 32'h0010_0000, "overflow");
    @(negedge clk);
    chk("error_sticky", error, 1);
    run_job(64, 64, "after_overflow");
    chk("error_clear", error, 0);

    repeat (20) begin
      if ($urandom_range(0, 7) == 0)
        run_job($urandom_range(0, 70), $urandom_range(0, 70), "rand_small");
      else
        run_job($urandom_range(0, 500), $urandom_range(0, 500), "rand");
    end

    hold_comb = 1;
    model_job(128, 128, err, ni);
    start_job(128, 128);
    n = 0;
    while (!comb_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_comb_seen", comb_valid, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outputs_zero", any_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    expq.delete();
    hold_comb = 0;
    repeat (5) @(negedge clk);
    chk("rst_mid_stays_idle",
        {61'd0, busy, leaf_valid, comb_valid}, 0);
    run_job(100, 40, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flexka_recursion_sequencer.md
Name: flexka_recursion_sequencer

Overview:
- Walks the Karatsuba recursion tree depth-first for one multiplication job.
- Drives push/pop of the per-depth operand-size stack node and keeps a per-depth child index internally.
- Emits leaf multiply jobs to the base multiplier array, and one combine job per internal node to the recombination unit.
- Sits between the top-level job dispatcher and the leaf multiplier and combine datapaths.

Parameters:
- SSIZE, 32, width of all operand-size and depth fields.
- LEAF_SIZE, 64, node is a leaf when both sizes are <= LEAF_SIZE; must be >= 4.
- MAX_DEPTH, 8, maximum push depth; must be <= stack buffer depth.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  job request, accepted only in IDLE
- size_A, size_B  in  SSIZE each  top-level operand sizes in bits
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle completion pulse
- error  out  1  sticky depth overflow flag, cleared on next accepted start
- leaf_valid  out  1  / leaf_ready  in  1  leaf job handshake
- leaf_size_A, leaf_size_B  out  SSIZE each  leaf operand sizes
- leaf_depth  out  SSIZE  depth of the leaf job
- leaf_child  out  2  child index of the leaf job: 0 low, 1 high, 2 mid
- comb_valid  out  1  / comb_ready  in  1  combine job handshake
- comb_size_A, comb_size_B  out  SSIZE each  parent node sizes
- comb_depth  out  SSIZE  depth of the combine job
- stk_push, stk_pop  out  1 each  stack controls
- stk_in_A2, stk_in_B2  out  SSIZE each  sizes written on push
- stk_top_A2, stk_top_B2  in  SSIZE each  popped entry, valid the cycle after stk_pop
- depth  out  SSIZE  current recursion depth

Behaviour:
- Reset: state IDLE, depth=0, current sizes=0, child indices=0. All outputs are 0, including error.
- States: IDLE, EVAL, LEAF, DESCEND, RETURN, RESTORE, COMBINE, DONE.
- IDLE:
  - On start: cur=(size_A,size_B), depth=0, clear error, go to EVAL.
  - start is ignored in every other state.
- EVAL:
  - If cur_A==0 or cur_B==0: go to RETURN (empty child, no job).
  - Else if both sizes <= LEAF_SIZE: go to LEAF.
  - Else go to DESCEND.
- LEAF:
  - leaf_valid=1 with cur sizes, depth, and child index; held stable until leaf_ready.
  - Transfer completes on valid&ready, then go to RETURN.
- Split rule:
  - h=(max(A,B)+1)>>1, computed at SSIZE+1 bits.
  - child0=(min(A,h), min(B,h)).
  - child1=(A-h, B-h), each saturated at 0.
  - child2=(h+1, h+1).
- DESCEND (1 cycle):
  - If depth==MAX_DEPTH: set error=1 and go to DONE; no push.
  - Else stk_push=1 with stk_in=cur, child_idx[depth]=0, cur=child0, depth+1, go to EVAL.
- RETURN:
  - If depth==0: go to DONE.
  - Else stk_pop=1, depth-1, go to RESTORE.
- RESTORE:
  - parent=stk_top, k=child_idx[depth].
  - If k<2: stk_push=1 with parent, child_idx[depth]=k+1, cur=child(k+1) of parent, depth+1, go to EVAL.
  - If k==2: go to COMBINE with comb sizes=parent.
- COMBINE:
  - comb_valid=1 with comb sizes and comb_depth=depth; held until comb_ready.
  - On handshake: cur=parent, go to RETURN.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Push and pop are never asserted in the same cycle. At most one of leaf_valid or comb_valid is high at a time.
- Reset mid-job: abandon immediately and return to reset values; no further jobs issue. The stack node is reset by the shared reset.

Test Plan:
- A=B=64 -> exactly one leaf (64,64,d0,c0), no push or pop, done after the handshake; error=0.
- A=B=128 -> leaves in order (64,64,d1,c0), (64,64,d1,c1), (33,33,d2,c0), (32,32,d2,c1), (34,34,d2,c2); then combine (65,65,d1), then combine (128,128,d0); then done.
- A=100, B=40 -> leaf (50,40,d1,c0), child1 (50,0) skipped, leaf (51,51,d1,c2), combine (100,40,d0).
- leaf_ready held low 10 cycles -> leaf outputs stable, no stk_push/stk_pop, depth unchanged; then resumes.
- MAX_DEPTH=1, A=B=1024 -> error=1, done pulses, no leaf beyond depth 1; next start clears error.
- rst asserted while in COMBINE -> next cycle all outputs 0, state IDLE; a fresh start runs normally.
